jvo_pulse_table_loader: RTL

- Double-buffered timing-table stage directly upstream of the pulse-generator counter/IO loop.
- Software writes a complete pulse table into a shadow bank through a valid/ready write port, then issues a commit.
- The active bank drives the generator's cnt_beg/cnt_end/io_init/max_count. A commit is applied atomically at a cycle boundary, so a running sequence never sees a half-updated table.

---
 rtl/jvo_pulse_table_loader.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/jvo_pulse_table_loader.sv
// jvo_pulse_table_loader
//   Double-buffered pulse-timing table. Software fills a shadow bank through a
//   valid/ready write port and then writes the commit address. The shadow bank
//   is copied to the active bank in a single edge, either while the generator is
//   stopped or on a counter wrap. The generator therefore never sees a partly
//   updated table.
//
//   Optional feature (macro JVO_TABLE_READBACK_EN): registered readback of the
//   active bank through rd_en/rd_addr/rd_data/rd_valid.
//
// Ports
//   clk, rst          system clock, synchronous active-high reset
//   wr_valid/ready    write handshake; ready is low while a commit is armed
//   wr_addr/wr_data   register map: 0..NCH-1 beg, NCH..2NCH-1 end,
//                     2NCH io_init, 2NCH+1 max_count, 2NCH+2 commit
//   run, cycle_end    generator status; the swap happens on (!run || cycle_end)
//   cnt_beg_flat      active start counts, channel c at [32c+31:32c]
//   cnt_end_flat      active end counts, same packing
//   io_init           active idle levels
//   max_count         active inclusive period
//   pending           a commit is armed and the swap has not happened yet
//   swap_done         one-cycle pulse while the new active values first show
//   err               sticky flag: unmapped address or commit with max_count==0
//   rd_en/rd_addr/rd_data/rd_valid (JVO_TABLE_READBACK_EN only)
module jvo_pulse_table_loader #(
  parameter int NCH    = 20,
  parameter int ADDR_W = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [31:0]         wr_data,
  input  logic                run,
  input  logic                cycle_end,
  output logic [32*NCH-1:0]   cnt_beg_flat,
  output logic [32*NCH-1:0]   cnt_end_flat,
  output logic [31:0]         io_init,
  output logic [31:0]         max_count,
  output logic                pending,
  output logic                swap_done,
  output logic                err
`ifdef JVO_TABLE_READBACK_EN
  ,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [31:0]         rd_data,
  output logic                rd_valid
`endif
);

  localparam logic [ADDR_W-1:0] A_IO     = ADDR_W'(2*NCH);
  localparam logic [ADDR_W-1:0] A_MAX    = ADDR_W'(2*NCH+1);
  localparam logic [ADDR_W-1:0] A_COMMIT = ADDR_W'(2*NCH+2);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_ARMED = 1'b1
  } state_e;

  state_e              state_q;
  logic                wr_ready_q;
  logic                pending_q;
  logic                swap_done_q;
  logic                err_q;

  logic [31:0]         sh_beg_q [NCH];
  logic [31:0]         sh_end_q [NCH];
  logic [31:0]         sh_io_q;
  logic [31:0]         sh_max_q;

  logic [32*NCH-1:0]   act_beg_q;
  logic [32*NCH-1:0]   act_end_q;
  logic [31:0]         act_io_q;
  logic [31:0]         act_max_q;

  logic                wr_fire;
  logic                swap_now;

  assign wr_fire  = wr_valid && wr_ready_q;
  assign swap_now = (state_q == S_ARMED) && (!run || cycle_end);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wr_ready_q  <= 1'b1;
      pending_q   <= 1'b0;
      swap_done_q <= 1'b0;
      err_q       <= 1'b0;
      for (int unsigned c = 0; c < NCH; c++) begin
        sh_beg_q[c] <= '0;
        sh_end_q[c] <= '0;
      end
      sh_io_q     <= '0;
      sh_max_q    <= '0;
      act_beg_q   <= '0;
      act_end_q   <= '0;
      act_io_q    <= '0;
      act_max_q   <= '0;
    end else begin
      swap_done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (wr_fire) begin
            for (int unsigned c = 0; c < NCH; c++) begin
              if (wr_addr == ADDR_W'(c))       sh_beg_q[c] <= wr_data;
              if (wr_addr == ADDR_W'(NCH + c)) sh_end_q[c] <= wr_data;
            end
            if (wr_addr == A_IO)  sh_io_q  <= wr_data;
            if (wr_addr == A_MAX) sh_max_q <= wr_data;
            if (wr_addr == A_COMMIT) begin
              // A zero period would stall the generator, so refuse to arm.
              if (sh_max_q == '0) begin
                err_q <= 1'b1;
              end else begin
                state_q    <= S_ARMED;
                wr_ready_q <= 1'b0;
                pending_q  <= 1'b1;
              end
            end
            // The map is contiguous from 0 to the commit address.
            if (wr_addr > A_COMMIT) err_q <= 1'b1;
          end
        end
        S_ARMED: begin
          // Only evaluated from the cycle after the commit, so a cycle_end
          // coincident with the commit write is deliberately ignored.
          if (swap_now) begin
            for (int unsigned c = 0; c < NCH; c++) begin
              act_beg_q[32*c +: 32] <= sh_beg_q[c];
              act_end_q[32*c +: 32] <= sh_end_q[c];
            end
            act_io_q    <= sh_io_q;
            act_max_q   <= sh_max_q;
            swap_done_q <= 1'b1;
            state_q     <= S_IDLE;
            wr_ready_q  <= 1'b1;
            pending_q   <= 1'b0;
          end
        end
      endcase
    end
  end

  assign wr_ready     = wr_ready_q;
  assign pending      = pending_q;
  assign swap_done    = swap_done_q;
  assign err          = err_q;
  assign cnt_beg_flat = act_beg_q;
  assign cnt_end_flat = act_end_q;
  assign io_init      = act_io_q;
  assign max_count    = act_max_q;

`ifdef JVO_TABLE_READBACK_EN
  logic [31:0] rd_mux;
  logic [31:0] rd_data_q;
  logic        rd_valid_q;

  always_comb begin
    rd_mux = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      if (rd_addr == ADDR_W'(c))       rd_mux = act_beg_q[32*c +: 32];
      if (rd_addr == ADDR_W'(NCH + c)) rd_mux = act_end_q[32*c +: 32];
    end
    if (rd_addr == A_IO)  rd_mux = act_io_q;
    if (rd_addr == A_MAX) rd_mux = act_max_q;
  end

  // Sampling the active registers before they update gives pre-swap data
  // for a read issued on the swap cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) rd_data_q <= rd_mux;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
`endif

endmodule
